et_scan: RTL
============

ET_SCAN -- requirements
Module: et_scan

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, entry index width (store depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 10, width of et/eta/phi fields.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  single-cycle scan request.
REQ-006 SHALL have port count  input  ADDR_W  number of stored entries, valid at indices 1..count; sampled with start.
REQ-007 SHALL have port rd_en  output  1  read strobe to particle store.
REQ-008 SHALL have port rd_index  output  ADDR_W  entry index being read.
REQ-009 SHALL have port rd_et, rd_eta, rd_phi  input  DATA_W each  store read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port busy  output  1  scan in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-012 SHALL have port empty  output  1  last scan had count = 0.
REQ-013 SHALL have port sum_et  output  DATA_W+ADDR_W  total et of scanned entries.
REQ-014 SHALL have ports max_et, max_eta, max_phi  output  DATA_W each  fields of highest-et entry.
REQ-015 SHALL have port max_index  output  ADDR_W  index of highest-et entry.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE; busy = 1 in ISSUE, DRAIN, DONE.
REQ-017 In IDLE, start = 1 SHALL latch count, clear sum_et/max_*/empty to 0, go to ISSUE (count > 0) or DONE (count = 0, empty set to 1).
REQ-018 In ISSUE SHALL assert rd_en for exactly count consecutive cycles, rd_index = 1, 2, ... count (index 0 never read).
REQ-019 After final issue SHALL enter DRAIN for 1 cycle to accept last read data, then DONE.
REQ-020 Each data beat (1 cycle after each rd_en) SHALL add rd_et to sum_et, zero-extended; no overflow possible by width.
REQ-021 Max update SHALL occur only when rd_et > max_et (strict); ties keep the lower index; first beat always loads if rd_et > 0.
REQ-022 If all et are 0, max_* SHALL remain 0 and max_index 0.
REQ-023 done SHALL pulse for 1 cycle in DONE; with start sampled at edge E0, done is high in the cycle after edge E0+count+2 (count = 0: after E0+1).
REQ-024 sum_et, max_*, empty SHALL hold stable from done until next accepted start.
REQ-025 start while busy = 1 SHALL be ignored, no queuing; count changes mid-scan SHALL have no effect.
REQ-026 rd_en SHALL be 0 in IDLE, DRAIN, DONE; rd_index holds last value when rd_en = 0.
REQ-027 count = 2^ADDR_W - 1 SHALL scan all indices 1..1023 without rd_index wrap.

Reset
REQ-028 rst = 0 SHALL immediately force state IDLE, rd_en = 0, rd_index = 0, busy = 0, done = 0, empty = 0, sum_et = 0, max_* = 0, independent of clk.
REQ-029 rst asserted mid-scan SHALL abort; no done pulse; first start after rst = 1 starts a fresh scan.

Verification
REQ-030 Store et = {5,9,3} at idx 1..3, eta/phi = idx, start with count=3 -> rd_index 1,2,3 consecutive, done 5 cycles after start edge, sum_et = 17, max_et = 9, max_index = 2, max_eta = max_phi = 2.
REQ-031 count = 0 -> no rd_en, done next cycle after start, empty = 1, sum_et = 0, max_et = 0.
REQ-032 et = {7,7,4} -> max_index = 1 (tie keeps first), sum_et = 18.
REQ-033 count = 1023, all et = 1023 -> sum_et = 1046529, max_index = 1, no rd_index wrap, done at cycle 1025.
REQ-034 rst = 0 during ISSUE at idx 5 of 10 -> outputs 0 at once, no done; new start count=2 -> correct fresh results.
REQ-035 start re-pulsed during busy with count=1 -> ignored; original scan completes with original count.

Source files
------------

// File: rtl/et_scan.sv
// Scans entries 1..count of a particle store, accumulating total et and tracking
// the highest-et entry (first occurrence wins on ties).
module et_scan #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        count,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_index,
    input  logic [DATA_W-1:0]        rd_et,
    input  logic [DATA_W-1:0]        rd_eta,
    input  logic [DATA_W-1:0]        rd_phi,
    output logic                     busy,
    output logic                     done,
    output logic                     empty,
    output logic [DATA_W+ADDR_W-1:0] sum_et,
    output logic [DATA_W-1:0]        max_et,
    output logic [DATA_W-1:0]        max_eta,
    output logic [DATA_W-1:0]        max_phi,
    output logic [ADDR_W-1:0]        max_index
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      pend_q, pend_d;
    logic [ADDR_W-1:0]         count_q, count_d;
    logic [ADDR_W-1:0]         rd_index_q, rd_index_d;
    logic                      beat_q, beat_d;
    logic [ADDR_W-1:0]         beat_idx_q, beat_idx_d;
    logic [DATA_W+ADDR_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0]         max_et_q, max_et_d;
    logic [DATA_W-1:0]         max_eta_q, max_eta_d;
    logic [DATA_W-1:0]         max_phi_q, max_phi_d;
    logic [ADDR_W-1:0]         max_index_q, max_index_d;
    logic                      empty_q, empty_d;
    logic                      accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sampled start is held for one cycle in pend_q before the scan begins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pend_q) state_d = (count_q == '0) ? DONE : ISSUE;
            ISSUE:   if (rd_index_q == count_q) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en = (state_q == ISSUE);
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
    end

    always_comb begin
        accept      = (state_q == IDLE) && !pend_q && start;
        pend_d      = accept;
        count_d     = accept ? count : count_q;
        rd_index_d  = rd_index_q;
        if ((state_q == IDLE) && pend_q && (count_q != '0)) begin
            rd_index_d = ADDR_W'(1);
        end else if ((state_q == ISSUE) && (rd_index_q != count_q)) begin
            rd_index_d = rd_index_q + ADDR_W'(1);
        end
        beat_d      = rd_en;
        beat_idx_d  = rd_en ? rd_index_q : beat_idx_q;
        sum_d       = sum_q;
        max_et_d    = max_et_q;
        max_eta_d   = max_eta_q;
        max_phi_d   = max_phi_q;
        max_index_d = max_index_q;
        empty_d     = empty_q;
        if (accept) begin
            sum_d       = '0;
            max_et_d    = '0;
            max_eta_d   = '0;
            max_phi_d   = '0;
            max_index_d = '0;
            empty_d     = (count == '0);
        end else if (beat_q) begin
            sum_d = sum_q + {{ADDR_W{1'b0}}, rd_et};
            // Strict compare keeps the earliest index on ties.
            if (rd_et > max_et_q) begin
                max_et_d    = rd_et;
                max_eta_d   = rd_eta;
                max_phi_d   = rd_phi;
                max_index_d = beat_idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= 1'b0;
            count_q     <= '0;
            rd_index_q  <= '0;
            beat_q      <= 1'b0;
            beat_idx_q  <= '0;
            sum_q       <= '0;
            max_et_q    <= '0;
            max_eta_q   <= '0;
            max_phi_q   <= '0;
            max_index_q <= '0;
            empty_q     <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            count_q     <= count_d;
            rd_index_q  <= rd_index_d;
            beat_q      <= beat_d;
            beat_idx_q  <= beat_idx_d;
            sum_q       <= sum_d;
            max_et_q    <= max_et_d;
            max_eta_q   <= max_eta_d;
            max_phi_q   <= max_phi_d;
            max_index_q <= max_index_d;
            empty_q     <= empty_d;
        end
    end

    assign rd_index  = rd_index_q;
    assign sum_et    = sum_q;
    assign max_et    = max_et_q;
    assign max_eta   = max_eta_q;
    assign max_phi   = max_phi_q;
    assign max_index = max_index_q;
    assign empty     = empty_q;

endmodule
